// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM h-vector collector: collector FSM states and
// default vector geometry.
package lstm_pkg;

   localparam int FEATURES_DEF     = 4;
   localparam int ELEMENT_BITS_DEF = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CAPTURE,
      S_HOLD
   } state_t;

endpackage

// File: rtl/lstm_h_collector.sv
// Requests serial readout of a finished LSTM cell's h vector, reassembles it into a
// packed word and offers it downstream with a valid/ready handshake.
module lstm_h_collector
   import lstm_pkg::*;
#(
   parameter int FEATURES     = FEATURES_DEF,
   parameter int ELEMENT_BITS = ELEMENT_BITS_DEF,
   parameter int RD_LAT       = 1
) (
   input  logic                             sys_clk,
   input  logic                             reset,
   input  logic                             done_wr,
   output logic                             read_output,
   input  logic [ELEMENT_BITS-1:0]          h_curr_ser,
   output logic [FEATURES*ELEMENT_BITS-1:0] h_vec,
   output logic                             h_valid,
   input  logic                             h_ready,
   output logic                             busy,
   output logic                             overrun
);

   localparam int IDX_W = (FEATURES > 1) ? $clog2(FEATURES) : 1;
   localparam int LAT_W = 3;

   state_t                           state_q, state_d;
   logic [LAT_W-1:0]                 lat_q, lat_d;
   logic [IDX_W-1:0]                 idx_q, idx_d;
   logic                             done_wr_q;
   logic                             overrun_q, overrun_d;
   logic [FEATURES*ELEMENT_BITS-1:0] h_vec_q, h_vec_d;
   logic                             rise;
   logic                             xfer;

   assign rise = done_wr & ~done_wr_q;
   assign xfer = (state_q == S_HOLD) & h_ready;

   always_comb begin
      state_d   = state_q;
      lat_d     = lat_q;
      idx_d     = idx_q;
      overrun_d = overrun_q;
      h_vec_d   = h_vec_q;
      case (state_q)
         S_IDLE: begin
            if (rise) state_d = S_REQ;
         end
         S_REQ: begin
            lat_d   = '0;
            idx_d   = '0;
            state_d = (RD_LAT == 1) ? S_CAPTURE : S_WAIT;
            if (rise) overrun_d = 1'b1;
         end
         S_WAIT: begin
            if (lat_q == LAT_W'(RD_LAT - 2)) state_d = S_CAPTURE;
            else                             lat_d   = lat_q + 1'b1;
            if (rise) overrun_d = 1'b1;
         end
         S_CAPTURE: begin
            h_vec_d[int'(idx_q)*ELEMENT_BITS +: ELEMENT_BITS] = h_curr_ser;
            if (idx_q == IDX_W'(FEATURES - 1)) state_d = S_HOLD;
            else                               idx_d   = idx_q + 1'b1;
            if (rise) overrun_d = 1'b1;
         end
         S_HOLD: begin
            // An edge coinciding with the handoff is the next vector, not a drop.
            if (xfer)      state_d   = rise ? S_REQ : S_IDLE;
            else if (rise) overrun_d = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         lat_q     <= '0;
         idx_q     <= '0;
         done_wr_q <= 1'b0;
         overrun_q <= 1'b0;
         h_vec_q   <= '0;
      end else begin
         state_q   <= state_d;
         lat_q     <= lat_d;
         idx_q     <= idx_d;
         done_wr_q <= done_wr;
         overrun_q <= overrun_d;
         h_vec_q   <= h_vec_d;
      end
   end

   assign read_output = (state_q == S_REQ);
   assign h_valid     = (state_q == S_HOLD);
   assign busy        = (state_q != S_IDLE);
   assign overrun     = overrun_q;
   assign h_vec       = h_vec_q;

endmodule

// File: tb/tb_lstm_h_collector.sv
// Directed bench for lstm_h_collector: one instance with RD_LAT=1, one with RD_LAT=3.
module tb_lstm_h_collector;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic        done_wr, h_ready, read_output, h_valid, busy, overrun;
   logic [7:0]  h_curr_ser;
   logic [31:0] h_vec;
   logic        done_wr3, h_ready3, read_output3, h_valid3, busy3, overrun3;
   logic [7:0]  h_curr_ser3;
   logic [31:0] h_vec3;

   int checks   = 0;
   int failures = 0;

   always #5 sys_clk = ~sys_clk;

   lstm_h_collector #(.FEATURES(4), .ELEMENT_BITS(8), .RD_LAT(1)) dut1 (
      .sys_clk(sys_clk), .reset(reset), .done_wr(done_wr), .read_output(read_output),
      .h_curr_ser(h_curr_ser), .h_vec(h_vec), .h_valid(h_valid), .h_ready(h_ready),
      .busy(busy), .overrun(overrun)
   );

   lstm_h_collector #(.FEATURES(4), .ELEMENT_BITS(8), .RD_LAT(3)) dut3 (
      .sys_clk(sys_clk), .reset(reset), .done_wr(done_wr3), .read_output(read_output3),
      .h_curr_ser(h_curr_ser3), .h_vec(h_vec3), .h_valid(h_valid3), .h_ready(h_ready3),
      .busy(busy3), .overrun(overrun3)
   );

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic feed(input logic [7:0] b);
      step();
      h_curr_ser = b;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1; done_wr = 1'b0; h_ready = 1'b1; h_curr_ser = 8'h00;
      done_wr3 = 1'b0; h_ready3 = 1'b1; h_curr_ser3 = 8'h00;
      step(); step();
      reset = 1'b0;
      chk("rst_read", read_output, 0); chk("rst_valid", h_valid, 0);
      chk("rst_busy", busy, 0);        chk("rst_ovr", overrun, 0);
      chk("rst_vec", h_vec, 0);        chk("rst3_busy", busy3, 0);
      chk("rst3_vec", h_vec3, 0);

      // basic capture, RD_LAT=1
      done_wr = 1'b1;
      step();
      chk("t1_read_R", read_output, 1); chk("t1_busy_R", busy, 1);
      feed(8'hB7);
      chk("t1_read_R1", read_output, 0); chk("t1_busy_R1", busy, 1);
      feed(8'hA7);
      feed(8'h18);
      chk("t1_partial", h_vec, 32'h0000A7B7);
      feed(8'h0F);
      chk("t1_valid_R4", h_valid, 0);
      step();
      chk("t1_valid_R5", h_valid, 1); chk("t1_vec", h_vec, 32'h0F18A7B7);
      step();
      chk("t1_valid_R6", h_valid, 0); chk("t1_busy_R6", busy, 0);

      // backpressure
      done_wr = 1'b0; h_ready = 1'b0;
      step();
      done_wr = 1'b1;
      step();
      chk("t2_read_R", read_output, 1);
      feed(8'h11); feed(8'h22); feed(8'h33); feed(8'h44);
      step();
      chk("t2_valid_R5", h_valid, 1); chk("t2_vec_R5", h_vec, 32'h44332211);
      for (int i = 0; i < 10; i++) begin
         step();
         chk("t2_hold_valid", h_valid, 1);
         chk("t2_hold_vec", h_vec, 32'h44332211);
         chk("t2_hold_read", read_output, 0);
      end
      h_ready = 1'b1;
      step();
      chk("t2_valid_after", h_valid, 0); chk("t2_busy_after", busy, 0);
      chk("t2_ovr", overrun, 0);

      // overrun: second edge during CAPTURE
      done_wr = 1'b0;
      step();
      done_wr = 1'b1;
      step();
      chk("t3_read_R", read_output, 1);
      feed(8'h01); done_wr = 1'b0;
      feed(8'h02); done_wr = 1'b1;
      feed(8'h03);
      chk("t3_ovr", overrun, 1); chk("t3_read_R3", read_output, 0);
      feed(8'h04);
      chk("t3_read_R4", read_output, 0);
      step();
      chk("t3_valid", h_valid, 1); chk("t3_vec", h_vec, 32'h04030201);
      chk("t3_read_R5", read_output, 0);
      step();
      chk("t3_busy_R6", busy, 0);
      step();
      chk("t3_read_R7", read_output, 0); chk("t3_busy_R7", busy, 0);

      // back-to-back: edge in the HOLD transfer cycle; done_wr falls mid-capture
      h_ready = 1'b0; done_wr = 1'b0;
      step();
      done_wr = 1'b1;
      step();
      chk("t4_read_R", read_output, 1);
      feed(8'h55); done_wr = 1'b0;
      feed(8'h66); feed(8'h77); feed(8'h88);
      step();
      chk("t4_valid1", h_valid, 1); chk("t4_vec1", h_vec, 32'h88776655);
      done_wr = 1'b1; h_ready = 1'b1;
      step();
      chk("t4_read_R2", read_output, 1); chk("t4_valid_R2", h_valid, 0);
      feed(8'hC1); feed(8'hEF); feed(8'hAE); feed(8'h9A);
      step();
      chk("t4_valid2", h_valid, 1); chk("t4_vec2", h_vec, 32'h9AAEEFC1);
      step();
      chk("t4_valid_end", h_valid, 0); chk("t4_ovr_sticky", overrun, 1);

      // reset mid-capture
      done_wr = 1'b0;
      step();
      done_wr = 1'b1;
      step();
      feed(8'h12); feed(8'h34);
      step();
      reset = 1'b1; done_wr = 1'b0;
      step();
      reset = 1'b0;
      chk("t5_read", read_output, 0); chk("t5_valid", h_valid, 0);
      chk("t5_busy", busy, 0);        chk("t5_ovr", overrun, 0);
      chk("t5_vec", h_vec, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t5_idle_read", read_output, 0);
         chk("t5_idle_valid", h_valid, 0);
      end

      // done_wr already high at reset release counts as an edge
      reset = 1'b1; done_wr = 1'b1;
      step();
      reset = 1'b0;
      chk("t5b_read_rel", read_output, 0); chk("t5b_busy_rel", busy, 0);
      step();
      chk("t5b_read_R", read_output, 1);
      feed(8'hDE); feed(8'hAD); feed(8'hBE); feed(8'hEF);
      step();
      chk("t5b_valid", h_valid, 1); chk("t5b_vec", h_vec, 32'hEFBEADDE);
      step();
      chk("t5b_valid_end", h_valid, 0);

      // latency RD_LAT=3
      done_wr3 = 1'b1;
      step();
      chk("t6_read_R", read_output3, 1);
      step(); h_curr_ser3 = 8'hFF;
      chk("t6_read_R1", read_output3, 0); chk("t6_busy_R1", busy3, 1);
      step(); h_curr_ser3 = 8'hFF;
      step(); h_curr_ser3 = 8'hEB;
      step(); h_curr_ser3 = 8'h83;
      step(); h_curr_ser3 = 8'h5E;
      step(); h_curr_ser3 = 8'h1C;
      chk("t6_valid_R6", h_valid3, 0);
      step();
      chk("t6_valid_R7", h_valid3, 1); chk("t6_vec", h_vec3, 32'h1C5E83EB);
      step();
      chk("t6_valid_end", h_valid3, 0); chk("t6_ovr", overrun3, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lstm_h_collector.md
LSTM_H_COLLECTOR -- requirements
Module: lstm_h_collector

Interface
REQ-001 Parameter FEATURES, default 4: number of h elements per cell output vector.
REQ-002 Parameter ELEMENT_BITS, default 8: width of one element.
REQ-003 Parameter RD_LAT, default 1, range 1..7: sys_clk cycles from the read_output pulse to the first valid element on h_curr_ser.
REQ-004 sys_clk  in  1: single clock; every register is rising-edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 done_wr  in  1: level from the cell, high once h is written and readable.
REQ-007 read_output  out  1: single-cycle request that starts serial readout from the cell.
REQ-008 h_curr_ser  in  ELEMENT_BITS: serial h element stream from the cell.
REQ-009 h_vec  out  FEATURES*ELEMENT_BITS: packed h vector; element 0 occupies the LSBs.
REQ-010 h_valid  out  1: h_vec holds a complete vector.
REQ-011 h_ready  in  1: downstream accepts; a transfer occurs when h_valid and h_ready are both high.
REQ-012 busy  out  1: FSM is not in IDLE.
REQ-013 overrun  out  1: sticky flag; a done_wr rising edge was dropped.

Function
REQ-014 FSM states: IDLE, REQ, WAIT, CAPTURE, HOLD; the state register is the only control state apart from the counters and done_wr_q.
REQ-015 done_wr_q registers done_wr every cycle; a rising edge is done_wr=1 while done_wr_q=0.
REQ-016 IDLE->REQ on a rising edge; with no edge the FSM stays in IDLE.
REQ-017 read_output is high only in REQ, for exactly one cycle (cycle R); REQ->WAIT.
REQ-018 WAIT lasts RD_LAT-1 cycles using a latency counter; when RD_LAT=1, REQ goes directly to CAPTURE.
REQ-019 Element k (0..FEATURES-1) is sampled from h_curr_ser at the sys_clk edge ending cycle R+RD_LAT+k.
- Element k is written into h_vec[k*ELEMENT_BITS +: ELEMENT_BITS].
- A clog2(FEATURES)-bit index counter tracks k.
REQ-020 After element FEATURES-1 the FSM goes CAPTURE->HOLD.
- h_valid rises in cycle R+RD_LAT+FEATURES.
REQ-021 In HOLD, h_vec and h_valid stay stable until the transfer; then HOLD->IDLE and h_valid drops the next cycle.
REQ-022 A rising edge in the same cycle as the HOLD transfer is accepted: the next state is REQ, not IDLE.
REQ-023 A rising edge in any other non-IDLE cycle is dropped and sets overrun.
- overrun is cleared only by reset.
REQ-024 If done_wr falls during WAIT or CAPTURE, capture continues to completion; no abort.
REQ-025 h_vec is written only during CAPTURE; elements not yet written keep their previous values.
REQ-026 Data is captured without modification; no arithmetic or sign handling.

Reset
REQ-027 While reset is high at a sys_clk edge, the following take these values on the next cycle:
- state=IDLE, read_output=0, h_valid=0, busy=0, overrun=0.
- h_vec=0, counters=0, done_wr_q=0.
REQ-028 Reset mid-capture or mid-HOLD discards the partial or held vector; no read_output is issued after reset until a new rising edge.
REQ-029 done_wr already high when reset is released counts as a rising edge on the first cycle after reset.

Structure
REQ-030 The FSM state enum and the FEATURES/ELEMENT_BITS defaults belong in the shared package lstm_pkg.
REQ-031 Single module, no sub-modules; the latency and index counters are inline.

Verification
REQ-032 Basic capture, RD_LAT=1, h_ready=1:
- Stimulus: done_wr edge; stream B7,A7,18,0F from R+1.
- Response: read_output 1 cycle; h_vec=0x0F18A7B7; h_valid at R+5.
REQ-033 Backpressure:
- Stimulus: hold h_ready=0 for 10 cycles.
- Response: h_vec and h_valid stable for all 10 cycles; one transfer when h_ready=1; busy drops the next cycle.
REQ-034 Overrun:
- Stimulus: second done_wr edge during CAPTURE.
- Response: overrun=1; no second read_output; captured vector unaffected.
REQ-035 Back-to-back:
- Stimulus: done_wr edge in the HOLD transfer cycle.
- Response: read_output in the next cycle; second vector 0x9AAEEFC1 captured correctly.
REQ-036 Latency:
- Stimulus: RD_LAT=3; stream EB,83,5E,1C from R+3.
- Response: h_vec=0x1C5E83EB; h_valid at R+7.
REQ-037 Reset mid-capture:
- Stimulus: assert reset after 2 elements.
- Response: all outputs 0 next cycle; no h_valid until a new edge.
